// File: rtl/ibex_mem_arbiter_if.sv
// rtl/ibex_mem_arbiter_if.sv - core instr/data ports and shared memory port bundle.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface ibex_mem_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;

  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - shares one req/gnt/rvalid memory port between instr and data.
// Request path is combinational; an in-order ID FIFO routes responses back.
module ibex_mem_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter int DataPriority   = 0
) (
  input logic               clk,
  input logic               rstn,
  ibex_mem_arbiter_if.slave bus
);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_e;

  localparam logic       OWN_I    = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [2:0] CNT_MAX  = 3'(MaxOutstanding);
  localparam logic [1:0] PTR_LAST = 2'(MaxOutstanding - 1);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [2:0] count_q, count_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic       fifo_q [4];
  logic       fifo_d [4];

  logic owner;
  logic owner_req;
  logic pop;
  logic room;
  logic handshake;
  logic head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // A held owner is sticky; otherwise ties go to data or to whoever was not granted last.
  always_comb begin
    owner = OWN_I;
    if (state_q == HOLD) begin
      owner = owner_q;
    end else if (bus.instr_req_i && bus.data_req_i) begin
      owner = (DataPriority != 0) ? OWN_D : ~last_q;
    end else if (bus.data_req_i) begin
      owner = OWN_D;
    end
  end

  assign owner_req = (owner == OWN_D) ? bus.data_req_i : bus.instr_req_i;
  assign pop       = bus.mem_rvalid_i && (count_q != 3'd0);
  // A response retiring this cycle frees its slot for a same-cycle request.
  assign room      = (count_q != CNT_MAX) || pop;
  assign handshake = bus.mem_req_o && bus.mem_gnt_i;
  assign head      = fifo_q[rd_ptr_q];

  assign bus.mem_req_o   = owner_req && room && rstn;
  assign bus.instr_gnt_o = handshake && (owner == OWN_I);
  assign bus.data_gnt_o  = handshake && (owner == OWN_D);

  assign bus.mem_addr_o  = (owner == OWN_D) ? bus.data_addr_i  : bus.instr_addr_i;
  assign bus.mem_we_o    = (owner == OWN_D) ? bus.data_we_i    : 1'b0;
  assign bus.mem_be_o    = (owner == OWN_D) ? bus.data_be_i    : 4'hF;
  assign bus.mem_wdata_o = (owner == OWN_D) ? bus.data_wdata_i : 32'h0;

  assign bus.instr_rvalid_o = pop && (head == OWN_I);
  assign bus.data_rvalid_o  = pop && (head == OWN_D);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fifo_d   = fifo_q;

    case (state_q)
      ARB: begin
        if (bus.mem_req_o && !bus.mem_gnt_i) begin
          state_d = HOLD;
          owner_d = owner;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if (handshake) begin
      last_d           = owner;
      fifo_d[wr_ptr_q] = owner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + {2'b00, handshake} - {2'b00, pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARB;
      owner_q  <= OWN_I;
      last_q   <= OWN_I;
      count_q  <= 3'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= OWN_I;
      end
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb/tb_ibex_mem_arbiter.sv - directed vector bench for ibex_mem_arbiter.
module tb_ibex_mem_arbiter;

  localparam logic [31:0] INSTR_ADDR = 32'h0000_1000;
  localparam logic [31:0] DATA_WDATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  DATA_BE    = 4'h3;

  logic clk = 1'b0;
  logic rstn;
  logic rst1_n;

  ibex_mem_arbiter_if if0 ();
  ibex_mem_arbiter_if if1 ();

  ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(0)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if0)
  );

  ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1)) dut1 (
    .clk  (clk),
    .rstn (rst1_n),
    .bus  (if1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, g, rv;
    logic [31:0] rdata;
    logic [31:0] daddr;
    logic        e_req, e_ig, e_dg, e_irv, e_drv, e_own;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic ir, input logic dr, input logic g, input logic rv,
                              input logic [31:0] rdata, input logic [31:0] daddr,
                              input logic e_req, input logic e_ig, input logic e_dg,
                              input logic e_irv, input logic e_drv, input logic e_own);
    vec_t v;
    v.ir = ir; v.dr = dr; v.g = g; v.rv = rv; v.rdata = rdata; v.daddr = daddr;
    v.e_req = e_req; v.e_ig = e_ig; v.e_dg = e_dg;
    v.e_irv = e_irv; v.e_drv = e_drv; v.e_own = e_own;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(input vec_t v);
    if0.instr_req_i  = v.ir;
    if0.data_req_i   = v.dr;
    if0.mem_gnt_i    = v.g;
    if0.mem_rvalid_i = v.rv;
    if0.mem_rdata_i  = v.rdata;
    if0.data_addr_i  = v.daddr;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit no_wait);
    if (!no_wait) begin
      @(posedge clk);
      #1;
    end
    drive0(v);
    @(negedge clk);
    chk({tag, " mem_req"},      32'(if0.mem_req_o),      32'(v.e_req));
    chk({tag, " instr_gnt"},    32'(if0.instr_gnt_o),    32'(v.e_ig));
    chk({tag, " data_gnt"},     32'(if0.data_gnt_o),     32'(v.e_dg));
    chk({tag, " instr_rvalid"}, 32'(if0.instr_rvalid_o), 32'(v.e_irv));
    chk({tag, " data_rvalid"},  32'(if0.data_rvalid_o),  32'(v.e_drv));
    chk({tag, " instr_rdata"},  if0.instr_rdata_o,       v.rdata);
    chk({tag, " data_rdata"},   if0.data_rdata_o,        v.rdata);
    if (v.e_req) begin
      chk({tag, " mem_addr"},  if0.mem_addr_o,       v.e_own ? v.daddr : INSTR_ADDR);
      chk({tag, " mem_we"},    32'(if0.mem_we_o),    v.e_own ? 32'd1 : 32'd0);
      chk({tag, " mem_be"},    32'(if0.mem_be_o),    v.e_own ? 32'(DATA_BE) : 32'hF);
      chk({tag, " mem_wdata"}, if0.mem_wdata_o,      v.e_own ? DATA_WDATA : 32'h0);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " mem_req"},      32'(if0.mem_req_o),      32'd0);
    chk({tag, " instr_gnt"},    32'(if0.instr_gnt_o),    32'd0);
    chk({tag, " data_gnt"},     32'(if0.data_gnt_o),     32'd0);
    chk({tag, " instr_rvalid"}, 32'(if0.instr_rvalid_o), 32'd0);
    chk({tag, " data_rvalid"},  32'(if0.data_rvalid_o),  32'd0);
  endtask

  initial begin
    // Round-robin from reset, full FIFO stall, in-order response routing.
    vecs.push_back(mk(1,1,1,0, 32'h0,      32'h200, 1,0,1,0,0,1));
    vecs.push_back(mk(1,1,1,1, 32'h11,     32'h200, 1,1,0,0,1,0));
    vecs.push_back(mk(1,1,1,1, 32'h22,     32'h200, 1,0,1,1,0,1));
    vecs.push_back(mk(1,1,1,1, 32'h33,     32'h200, 1,1,0,0,1,0));
    vecs.push_back(mk(0,0,0,1, 32'h44,     32'h200, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,1, 32'h55,     32'h200, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0, 32'h0,      32'h200, 1,1,0,0,0,0));
    vecs.push_back(mk(1,0,1,0, 32'h0,      32'h200, 1,1,0,0,0,0));
    vecs.push_back(mk(1,0,1,0, 32'h0,      32'h200, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,1, 32'h66,     32'h200, 1,1,0,1,0,0));
    vecs.push_back(mk(0,0,0,1, 32'h77,     32'h200, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,1, 32'h88,     32'h200, 0,0,0,1,0,0));
    vecs.push_back(mk(1,0,1,0, 32'h0,      32'h300, 1,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,0, 32'h0,      32'h300, 1,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,1, 32'hAAAA,   32'h300, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,1, 32'hBBBB,   32'h300, 0,0,0,0,1,0));

    rstn = 1'b0;
    rst1_n = 1'b0;
    if0.instr_addr_i = INSTR_ADDR;
    if0.data_we_i    = 1'b1;
    if0.data_be_i    = DATA_BE;
    if0.data_wdata_i = DATA_WDATA;
    drive0(mk(1,1,1,1, 32'h0, 32'h200, 0,0,0,0,0,0));
    if1.instr_req_i  = 1'b0;
    if1.data_req_i   = 1'b0;
    if1.mem_gnt_i    = 1'b0;
    if1.mem_rvalid_i = 1'b0;
    if1.mem_rdata_i  = 32'h0;
    if1.instr_addr_i = INSTR_ADDR;
    if1.data_addr_i  = 32'h500;
    if1.data_we_i    = 1'b0;
    if1.data_be_i    = 4'hF;
    if1.data_wdata_i = 32'h0;

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    drive0(mk(0,0,0,0, 32'h0, 32'h200, 0,0,0,0,0,0));
    @(posedge clk);
    #1 rstn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i), i == 0);

    // Data owner held through a stalled grant while instr also requests.
    run_vec(mk(0,1,0,0, 32'h0,  32'h100, 1,0,0,0,0,1), "hold0", 1'b0);
    run_vec(mk(1,1,0,0, 32'h0,  32'h100, 1,0,0,0,0,1), "hold1", 1'b0);
    run_vec(mk(1,1,0,0, 32'h0,  32'h100, 1,0,0,0,0,1), "hold2", 1'b0);
    run_vec(mk(1,1,1,0, 32'h0,  32'h100, 1,0,1,0,0,1), "hold3", 1'b0);
    run_vec(mk(1,1,1,0, 32'h0,  32'h100, 1,1,0,0,0,0), "hold4", 1'b0);
    run_vec(mk(0,0,0,1, 32'h55, 32'h100, 0,0,0,0,1,0), "hold5", 1'b0);
    run_vec(mk(0,0,0,1, 32'h66, 32'h100, 0,0,0,1,0,0), "hold6", 1'b0);

    // Reset with two responses outstanding discards them.
    run_vec(mk(1,0,1,0, 32'h0,  32'h400, 1,1,0,0,0,0), "rst0", 1'b0);
    run_vec(mk(1,0,1,0, 32'h0,  32'h400, 1,1,0,0,0,0), "rst1", 1'b0);
    run_vec(mk(0,1,1,0, 32'h0,  32'h400, 0,0,0,0,0,1), "rst2", 1'b0);
    #2 rstn = 1'b0;
    #1 chk_quiet("midreset");
    @(posedge clk);
    #1 rstn = 1'b1;
    run_vec(mk(0,0,0,1, 32'h99, 32'h400, 0,0,0,0,0,0), "post0", 1'b1);
    run_vec(mk(0,1,1,0, 32'h0,  32'h400, 1,0,1,0,0,1), "post1", 1'b0);
    run_vec(mk(1,1,1,0, 32'h0,  32'h400, 1,1,0,0,0,0), "post2", 1'b0);

    // Data-priority instance: instr must never win while data requests.
    if1.instr_req_i  = 1'b1;
    if1.data_req_i   = 1'b1;
    if1.mem_gnt_i    = 1'b1;
    if1.mem_rvalid_i = 1'b1;
    @(posedge clk);
    #1 rst1_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("prio%0d instr_gnt", k),    32'(if1.instr_gnt_o),    32'd0);
      chk($sformatf("prio%0d data_gnt", k),     32'(if1.data_gnt_o),     32'd1);
      chk($sformatf("prio%0d instr_rvalid", k), 32'(if1.instr_rvalid_o), 32'd0);
      chk($sformatf("prio%0d mem_addr", k),     if1.mem_addr_o,          32'h500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2: the maximum number of granted requests still awaiting a response (range 1..4).
REQ-002 SHALL have parameter DataPriority, default 0: 0 = round-robin arbitration, 1 = the data port always wins a tie.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have instruction-side ports: instr_req_i in 1, instr_gnt_o out 1, instr_rvalid_o out 1, instr_addr_i in 32, instr_rdata_o out 32.
REQ-006 SHALL have data-side ports: data_req_i in 1, data_gnt_o out 1, data_rvalid_o out 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32, data_rdata_o out 32.
REQ-007 SHALL have memory-side ports: mem_req_o out 1, mem_gnt_i in 1, mem_rvalid_i in 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_rdata_i in 32.

Function
REQ-008 SHALL share one req/gnt/rvalid memory port between the core's instruction and data ports, with zero added request latency (the request path is combinational).
REQ-009 SHALL implement FSM states ARB and HOLD; reset state is ARB.
REQ-010 In ARB, the owner SHALL be chosen from the current requests as follows:
- only one requester: that requester wins;
- both requesting, DataPriority=1: data wins;
- both requesting, DataPriority=0: the requester not granted last wins.
REQ-011 In HOLD, the owner SHALL be the registered owner; new requests SHALL NOT change it.
REQ-012 mem_req_o SHALL equal (owner's req) AND (outstanding count < MaxOutstanding) AND rstn.
REQ-013 The address, we, be and wdata outputs SHALL be muxed from the owner. For an instr owner: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-014 A grant SHALL be routed only to the owner: owner gnt_o = mem_gnt_i AND mem_req_o. The non-owner gnt_o = 0.
REQ-015 FSM transitions:
- ARB -> HOLD when mem_req_o=1 and mem_gnt_i=0; the owner is registered.
- HOLD -> ARB on mem_req_o=1 and mem_gnt_i=1.
- Otherwise the state is unchanged.
REQ-016 On every handshake (mem_req_o & mem_gnt_i), the last-granted pointer SHALL update to the owner, and the owner ID SHALL be pushed into an in-order response FIFO of depth MaxOutstanding.
REQ-017 On mem_rvalid_i=1 with the FIFO non-empty, the head ID SHALL be popped and rvalid_o asserted for that requester only, in the same cycle.
REQ-018 Both rdata_o outputs SHALL equal mem_rdata_i combinationally.
REQ-019 A push and a pop in the same cycle SHALL leave the count unchanged and keep FIFO order.
REQ-020 When the count equals MaxOutstanding, mem_req_o SHALL be 0 and both gnt_o SHALL be 0. The requester stalls; a HOLD owner is retained.
REQ-021 mem_rvalid_i with an empty FIFO SHALL be dropped: no rvalid_o, and no state change.
REQ-022 The FIFO pointers SHALL wrap modulo MaxOutstanding.

Reset
REQ-023 While rstn=0, the block SHALL hold:
- state ARB, FIFO empty (count 0);
- last-granted pointer = instr;
- mem_req_o=0, instr_gnt_o=0, data_gnt_o=0, instr_rvalid_o=0, data_rvalid_o=0.
REQ-024 A reset asserted mid-transaction SHALL discard all outstanding IDs and any HOLD owner. Responses arriving after deassertion are dropped per REQ-021.
REQ-025 The first cycle after rstn deasserts SHALL arbitrate normally. With both requesting and DataPriority=0, data wins.

Verification
REQ-026 Both requesting from reset, mem_gnt_i=1, responses 1 cycle later, DataPriority=0 -> grants alternate data, instr, data, ...; rvalid_o goes to the matching requester each time.
REQ-027 Data req with addr 0x100, mem_gnt_i held 0 for 3 cycles, instr req raised in cycle 1 -> mem_addr_o stays 0x100 through HOLD; data_gnt_o pulses in cycle 4; instr is served next.
REQ-028 MaxOutstanding=2, two instr grants with no rvalid -> third request sees mem_req_o=0. One mem_rvalid_i -> instr_rvalid_o=1 and mem_req_o=1 the same cycle.
REQ-029 Instr granted then data granted, responses 0xAAAA then 0xBBBB -> instr_rvalid_o carries 0xAAAA, then data_rvalid_o carries 0xBBBB. Back-to-back push and pop keeps the count steady.
REQ-030 Pulse rstn low with 2 outstanding, then inject mem_rvalid_i -> no rvalid_o; next data request is granted normally.
REQ-031 DataPriority=1, both requesting continuously -> instr is never granted while data_req_i=1.
